// File: rtl/cpu_mem_arbiter_if.sv
// Bundle of the three sram-like ports that meet at the CPU/memory arbiter:
// the instruction-fetch port, the load/store port and the shared memory port.
// The slave modport is the arbiter's view. The master modport is the view of
// everything around it: the core driving requests and the memory answering them.
interface cpu_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction-fetch port (read only)
    logic                inst_req;
    logic [ADDR_W-1:0]   inst_addr;
    logic                inst_addr_ok;
    logic                inst_data_ok;
    logic [DATA_W-1:0]   inst_rdata;

    // Load/store port
    logic                data_req;
    logic                data_wr;
    logic [DATA_W/8-1:0] data_wstrb;
    logic [ADDR_W-1:0]   data_addr;
    logic [DATA_W-1:0]   data_wdata;
    logic                data_addr_ok;
    logic                data_data_ok;
    logic [DATA_W-1:0]   data_rdata;

    // Shared memory port
    logic                mem_req;
    logic                mem_wr;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_addr_ok;
    logic                mem_data_ok;
    logic [DATA_W-1:0]   mem_rdata;

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Merges the core's fetch and load/store sram-like ports onto one shared
// variable-latency memory port, one outstanding transaction at a time.
// Responses are steered back to whichever port owns the transaction.
// Default arbitration is fixed data-over-inst, because the data request
// belongs to the older instruction. Defining ARB_RR_EN switches to
// round-robin between the two ports when both request in the same cycle.
module cpu_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               resetn,
    cpu_mem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic                memWr_q, memWr_d;
    logic [DATA_W/8-1:0] memWstrb_q, memWstrb_d;
    logic [ADDR_W-1:0]   memAddr_q, memAddr_d;
    logic [DATA_W-1:0]   memWdata_q, memWdata_d;

    logic                grantData;
    logic                grantInst;
    logic                respValid;

`ifdef ARB_RR_EN
    owner_t              lastGrant_q, lastGrant_d;

    // Round-robin grant: on a tie the port not served last wins.
    always_comb begin
        grantData = 1'b0;
        grantInst = 1'b0;
        if (resetn && state_q == IDLE) begin
            if (bus.data_req && bus.inst_req) begin
                if (lastGrant_q == OWN_DATA) begin
                    grantInst = 1'b1;
                end else begin
                    grantData = 1'b1;
                end
            end else begin
                grantData = bus.data_req;
                grantInst = bus.inst_req;
            end
        end
    end

    // Remember which port received the most recent grant.
    always_comb begin
        lastGrant_d = lastGrant_q;
        if (grantData) begin
            lastGrant_d = OWN_DATA;
        end else if (grantInst) begin
            lastGrant_d = OWN_INST;
        end
    end

    // Last-grant register for the round-robin tie break.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lastGrant_q <= OWN_INST;
        end else begin
            lastGrant_q <= lastGrant_d;
        end
    end
`else
    // Fixed-priority grant: a data request always beats a fetch.
    always_comb begin
        grantData = 1'b0;
        grantInst = 1'b0;
        if (resetn && state_q == IDLE) begin
            grantData = bus.data_req;
            grantInst = bus.inst_req & ~bus.data_req;
        end
    end
`endif

    // Next state and latching of the shared-port fields on an IDLE grant.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        memWr_d    = memWr_q;
        memWstrb_d = memWstrb_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        case (state_q)
            IDLE: begin
                if (grantData) begin
                    owner_d    = OWN_DATA;
                    memWr_d    = bus.data_wr;
                    memWstrb_d = bus.data_wstrb;
                    memAddr_d  = bus.data_addr;
                    memWdata_d = bus.data_wdata;
                    state_d    = REQ;
                end else if (grantInst) begin
                    owner_d    = OWN_INST;
                    memWr_d    = 1'b0;
                    memWstrb_d = '0;
                    memAddr_d  = bus.inst_addr;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (bus.mem_addr_ok) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.mem_data_ok) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, owner and latched shared-port fields; reset drops any transaction.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            owner_q    <= OWN_INST;
            memWr_q    <= 1'b0;
            memWstrb_q <= '0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            memWr_q    <= memWr_d;
            memWstrb_q <= memWstrb_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
        end
    end

    // Port-facing outputs: grants, owner-steered responses and the shared request.
    always_comb begin
        respValid         = (state_q == RESP) && bus.mem_data_ok;
        bus.inst_addr_ok  = grantInst;
        bus.data_addr_ok  = grantData;
        bus.inst_data_ok  = respValid && (owner_q == OWN_INST);
        bus.data_data_ok  = respValid && (owner_q == OWN_DATA);
        bus.inst_rdata    = '0;
        bus.data_rdata    = '0;
        if (bus.inst_data_ok) begin
            bus.inst_rdata = bus.mem_rdata;
        end
        if (bus.data_data_ok && !memWr_q) begin
            bus.data_rdata = bus.mem_rdata;
        end
        bus.mem_req   = (state_q == REQ);
        bus.mem_wr    = memWr_q;
        bus.mem_wstrb = memWstrb_q;
        bus.mem_addr  = memAddr_q;
        bus.mem_wdata = memWdata_q;
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed testbench for cpu_mem_arbiter. The bench plays both the core
// and the memory through the interface, one cycle per step, and compares the
// arbiter outputs to hand-computed values a few ns after each rising edge.
module tb_cpu_mem_arbiter;

    logic clk    = 1'b0;
    logic resetn = 1'b1;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    logic expInstFirst;

    cpu_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the core-side request fields of both ports
    task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                                 input logic dReq, input logic dWr,
                                 input logic [3:0] dWstrb, input logic [31:0] dAddr,
                                 input logic [31:0] dWdata);
        bus.inst_req   = iReq;
        bus.inst_addr  = iAddr;
        bus.data_req   = dReq;
        bus.data_wr    = dWr;
        bus.data_wstrb = dWstrb;
        bus.data_addr  = dAddr;
        bus.data_wdata = dWdata;
        #1;
    endtask

    // Drive the memory-side response fields
    task automatic setMem(input logic addrOk, input logic dataOk, input logic [31:0] rdata);
        bus.mem_addr_ok = addrOk;
        bus.mem_data_ok = dataOk;
        bus.mem_rdata   = rdata;
        #1;
    endtask

    // One comparison: count it, and report tag/observed/expected on a miss
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence of steps
    initial begin
`ifdef ARB_RR_EN
        expInstFirst = 1'b1;
`else
        expInstFirst = 1'b0;
`endif
        applyStimulus(1'b1, 32'h1C000000, 1'b1, 1'b1, 4'hF, 32'h1000, 32'h1);
        setMem(1'b0, 1'b0, 32'h0);

        // Reset state, with both ports requesting
        resetn = 1'b0;
        #1;
        checkOutput("rst_inst_addr_ok", 64'(bus.inst_addr_ok), 64'd0);
        checkOutput("rst_data_addr_ok", 64'(bus.data_addr_ok), 64'd0);
        checkOutput("rst_mem_req",      64'(bus.mem_req),      64'd0);
        checkOutput("rst_mem_wr",       64'(bus.mem_wr),       64'd0);
        checkOutput("rst_mem_wstrb",    64'(bus.mem_wstrb),    64'd0);
        checkOutput("rst_mem_addr",     64'(bus.mem_addr),     64'd0);
        checkOutput("rst_mem_wdata",    64'(bus.mem_wdata),    64'd0);
        checkOutput("rst_inst_rdata",   64'(bus.inst_rdata),   64'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        tick();
        resetn = 1'b1;
        $display("[TB] reset released");

        // Single fetch
        tick();
        applyStimulus(1'b1, 32'h1C000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("f_inst_addr_ok", 64'(bus.inst_addr_ok), 64'd1);
        checkOutput("f_data_addr_ok", 64'(bus.data_addr_ok), 64'd0);
        checkOutput("f_mem_req_c0",   64'(bus.mem_req),      64'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        setMem(1'b1, 1'b0, 32'h0);
        checkOutput("f_mem_req_c1",   64'(bus.mem_req),      64'd1);
        checkOutput("f_mem_addr",     64'(bus.mem_addr),     64'h1C000000);
        checkOutput("f_mem_wr",       64'(bus.mem_wr),       64'd0);
        checkOutput("f_inst_data_ok_c1", 64'(bus.inst_data_ok), 64'd0);
        tick();
        setMem(1'b0, 1'b1, 32'h02800406);
        checkOutput("f_mem_req_c2",   64'(bus.mem_req),      64'd0);
        checkOutput("f_inst_data_ok", 64'(bus.inst_data_ok), 64'd1);
        checkOutput("f_inst_rdata",   64'(bus.inst_rdata),   64'h02800406);
        checkOutput("f_data_data_ok", 64'(bus.data_data_ok), 64'd0);
        tick();
        setMem(1'b0, 1'b0, 32'h0);
        checkOutput("f_inst_data_ok_c3", 64'(bus.inst_data_ok), 64'd0);
        checkOutput("f_inst_rdata_c3",   64'(bus.inst_rdata),   64'd0);

        // Store with five cycles of memory backpressure
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h00001000, 32'hDEADBEEF);
        checkOutput("s_data_addr_ok", 64'(bus.data_addr_ok), 64'd1);
        checkOutput("s_inst_addr_ok", 64'(bus.inst_addr_ok), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            applyStimulus(1'b1, 32'h1C000020, 1'b1, 1'b0, 4'h3, 32'h3000, 32'h0BADF00D);
            checkOutput("bp_mem_req",      64'(bus.mem_req),      64'd1);
            checkOutput("bp_mem_wr",       64'(bus.mem_wr),       64'd1);
            checkOutput("bp_mem_wstrb",    64'(bus.mem_wstrb),    64'hF);
            checkOutput("bp_mem_addr",     64'(bus.mem_addr),     64'h1000);
            checkOutput("bp_mem_wdata",    64'(bus.mem_wdata),    64'hDEADBEEF);
            checkOutput("bp_inst_addr_ok", 64'(bus.inst_addr_ok), 64'd0);
            checkOutput("bp_data_addr_ok", 64'(bus.data_addr_ok), 64'd0);
        end
        tick();
        applyStimulus(1'b1, 32'h1C000020, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        setMem(1'b1, 1'b0, 32'h0);
        checkOutput("s_mem_req_ack",  64'(bus.mem_req),      64'd1);
        checkOutput("s_mem_addr_ack", 64'(bus.mem_addr),     64'h1000);
        tick();
        setMem(1'b0, 1'b1, 32'h12345678);
        checkOutput("s_data_data_ok", 64'(bus.data_data_ok), 64'd1);
        checkOutput("s_data_rdata",   64'(bus.data_rdata),   64'd0);
        checkOutput("s_inst_data_ok", 64'(bus.inst_data_ok), 64'd0);
        checkOutput("s_inst_addr_ok_resp", 64'(bus.inst_addr_ok), 64'd0);
        checkOutput("s_mem_req_resp", 64'(bus.mem_req),      64'd0);
        tick();
        setMem(1'b0, 1'b0, 32'h0);
        checkOutput("s_pending_inst_grant", 64'(bus.inst_addr_ok), 64'd1);
        checkOutput("s_data_data_ok_once",  64'(bus.data_data_ok), 64'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        setMem(1'b1, 1'b0, 32'h0);
        checkOutput("p_mem_addr",  64'(bus.mem_addr),  64'h1C000020);
        checkOutput("p_mem_wr",    64'(bus.mem_wr),    64'd0);
        checkOutput("p_mem_wstrb", 64'(bus.mem_wstrb), 64'd0);
        tick();
        setMem(1'b0, 1'b1, 32'hA5A5A5A5);
        checkOutput("p_inst_data_ok", 64'(bus.inst_data_ok), 64'd1);
        checkOutput("p_inst_rdata",   64'(bus.inst_rdata),   64'hA5A5A5A5);
        tick();
        setMem(1'b0, 1'b0, 32'h0);

        // Conflict: load and fetch together, last grant was a fetch
        tick();
        applyStimulus(1'b1, 32'h1C000010, 1'b1, 1'b0, 4'h0, 32'h00002000, 32'h0);
        checkOutput("c_data_addr_ok", 64'(bus.data_addr_ok), 64'd1);
        checkOutput("c_inst_addr_ok", 64'(bus.inst_addr_ok), 64'd0);
        tick();
        applyStimulus(1'b1, 32'h1C000010, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        setMem(1'b1, 1'b0, 32'h0);
        checkOutput("c_mem_addr",      64'(bus.mem_addr),     64'h2000);
        checkOutput("c_mem_wr",        64'(bus.mem_wr),       64'd0);
        checkOutput("c_inst_held",     64'(bus.inst_addr_ok), 64'd0);
        tick();
        setMem(1'b0, 1'b1, 32'hCAFEF00D);
        checkOutput("c_data_data_ok", 64'(bus.data_data_ok), 64'd1);
        checkOutput("c_data_rdata",   64'(bus.data_rdata),   64'hCAFEF00D);
        checkOutput("c_inst_data_ok", 64'(bus.inst_data_ok), 64'd0);
        checkOutput("c_inst_rdata",   64'(bus.inst_rdata),   64'd0);
        tick();
        setMem(1'b0, 1'b0, 32'h0);
        checkOutput("c_inst_granted", 64'(bus.inst_addr_ok), 64'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        setMem(1'b1, 1'b0, 32'h0);
        checkOutput("c_mem_addr_inst", 64'(bus.mem_addr), 64'h1C000010);
        tick();
        setMem(1'b0, 1'b1, 32'h11223344);
        checkOutput("c_inst_rdata_2", 64'(bus.inst_rdata), 64'h11223344);

        // Lone load, then a tie whose winner depends on the arbitration mode
        tick();
        setMem(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h00002004, 32'h0);
        checkOutput("r_lone_data_grant", 64'(bus.data_addr_ok), 64'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        setMem(1'b1, 1'b0, 32'h0);
        tick();
        setMem(1'b0, 1'b1, 32'h55667788);
        checkOutput("r_data_rdata", 64'(bus.data_rdata), 64'h55667788);
        tick();
        setMem(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h1C000014, 1'b1, 1'b0, 4'h0, 32'h00002008, 32'h0);
        checkOutput("r_tie_inst_addr_ok", 64'(bus.inst_addr_ok), 64'(expInstFirst));
        checkOutput("r_tie_data_addr_ok", 64'(bus.data_addr_ok), 64'(!expInstFirst));
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        setMem(1'b1, 1'b0, 32'h0);
        checkOutput("r_tie_mem_addr", 64'(bus.mem_addr),
                    expInstFirst ? 64'h1C000014 : 64'h2008);
        tick();
        setMem(1'b0, 1'b1, 32'h00000009);
        checkOutput("r_tie_inst_data_ok", 64'(bus.inst_data_ok), 64'(expInstFirst));
        tick();
        setMem(1'b0, 1'b0, 32'h0);

        // Stray responses in IDLE and REQ are ignored
        tick();
        setMem(1'b0, 1'b1, 32'hDEAD0000);
        checkOutput("x_idle_inst_data_ok", 64'(bus.inst_data_ok), 64'd0);
        checkOutput("x_idle_data_data_ok", 64'(bus.data_data_ok), 64'd0);
        checkOutput("x_idle_inst_rdata",   64'(bus.inst_rdata),   64'd0);
        checkOutput("x_idle_mem_req",      64'(bus.mem_req),      64'd0);
        tick();
        setMem(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h1C000018, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("x_still_idle", 64'(bus.inst_addr_ok), 64'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        setMem(1'b0, 1'b1, 32'hFFFF0000);
        checkOutput("x_req_mem_req",      64'(bus.mem_req),      64'd1);
        checkOutput("x_req_inst_data_ok", 64'(bus.inst_data_ok), 64'd0);
        tick();
        setMem(1'b0, 1'b0, 32'h0);
        checkOutput("x_req_held", 64'(bus.mem_req), 64'd1);
        tick();
        setMem(1'b1, 1'b0, 32'h0);
        tick();
        setMem(1'b0, 1'b1, 32'h13572468);
        checkOutput("x_inst_data_ok", 64'(bus.inst_data_ok), 64'd1);
        checkOutput("x_inst_rdata",   64'(bus.inst_rdata),   64'h13572468);
        tick();
        setMem(1'b0, 1'b0, 32'h0);

        // Reset while waiting for the response
        tick();
        applyStimulus(1'b1, 32'h1C00000C, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("z_accept", 64'(bus.inst_addr_ok), 64'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        setMem(1'b1, 1'b0, 32'h0);
        tick();
        setMem(1'b0, 1'b0, 32'h0);
        checkOutput("z_in_resp", 64'(bus.mem_req), 64'd0);
        applyStimulus(1'b1, 32'h1C000030, 1'b1, 1'b1, 4'hF, 32'h4000, 32'h77);
        setMem(1'b0, 1'b1, 32'hAAAA5555);
        resetn = 1'b0;
        #1;
        checkOutput("z_rst_inst_data_ok", 64'(bus.inst_data_ok), 64'd0);
        checkOutput("z_rst_inst_rdata",   64'(bus.inst_rdata),   64'd0);
        checkOutput("z_rst_inst_addr_ok", 64'(bus.inst_addr_ok), 64'd0);
        checkOutput("z_rst_data_addr_ok", 64'(bus.data_addr_ok), 64'd0);
        checkOutput("z_rst_mem_addr",     64'(bus.mem_addr),     64'd0);
        checkOutput("z_rst_mem_wdata",    64'(bus.mem_wdata),    64'd0);
        checkOutput("z_rst_mem_wr",       64'(bus.mem_wr),       64'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        setMem(1'b0, 1'b0, 32'h0);
        resetn = 1'b1;
        tick();
        applyStimulus(1'b1, 32'h1C000004, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("z_post_accept",  64'(bus.inst_addr_ok), 64'd1);
        checkOutput("z_post_mem_req", 64'(bus.mem_req),      64'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        setMem(1'b1, 1'b0, 32'h0);
        checkOutput("z_post_req",  64'(bus.mem_req),  64'd1);
        checkOutput("z_post_addr", 64'(bus.mem_addr), 64'h1C000004);
        tick();
        setMem(1'b0, 1'b1, 32'h0BEEF001);
        checkOutput("z_post_data_ok", 64'(bus.inst_data_ok), 64'd1);
        checkOutput("z_post_rdata",   64'(bus.inst_rdata),   64'h0BEEF001);
        tick();
        setMem(1'b0, 1'b0, 32'h0);
        checkOutput("z_post_idle_data_ok", 64'(bus.inst_data_ok), 64'd0);
        checkOutput("z_post_idle_mem_req", 64'(bus.mem_req),      64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
